xor_cksum_ctrl: RTL and testbench

Sequencer that computes a 32-bit XOR checksum over a block of words in data memory. It sits beside the datapath's 32-bit bitwise XOR unit, issues word reads over a req/ack memory port, folds each returned word into an accumulator, and reports the result with a one-cycle done pulse. It is used for memory self-check and for image integrity checks after load.

---
 rtl/xor_cksum_ctrl.sv | 144 ++++++++++++++
 tb/tb_xor_cksum_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cksum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xor_cksum_ctrl
//  Purpose  : Sequencer that reads a block of 32-bit words through a req/ack
//             memory port, folds each word into an accumulator and reports the
//             32-bit checksum with a one-cycle done pulse.
//  Option   : XOR_CKSUM_ROTATE_EN - when defined, the accumulator is rotated
//             left by one bit before each XOR (order-dependent checksum).
//             When undefined, the fold is a plain bitwise XOR.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_cksum_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] word_count,
    input  logic             abort,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] C_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] C_ZERO = '0;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        checksum_q, checksum_d;
    logic               mem_req_q, mem_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        w_fold;

    // Low address bits are forced to zero, so they never reach the datapath.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^base_addr[1:0];

    // One fold step of the accumulator with the word returned by memory.
`ifdef XOR_CKSUM_ROTATE_EN
    assign w_fold = {acc_q[30:0], acc_q[31]} ^ mem_rdata;
`else
    assign w_fold = acc_q ^ mem_rdata;
`endif

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            remaining_q <= C_ZERO;
            acc_q       <= 32'h0;
            checksum_q  <= 32'h0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            checksum_q  <= checksum_d;
            mem_req_q   <= mem_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = {base_addr[31:2], 2'b00};
                    remaining_d = word_count;
                    acc_d       = 32'h0;
                    if (word_count == C_ZERO) begin
                        // Empty block: the result is the cleared accumulator.
                        state_d    = S_DONE;
                        checksum_d = 32'h0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (abort) begin
                    // Abort beats a coincident ack; the word is dropped.
                    state_d     = S_IDLE;
                    acc_d       = 32'h0;
                    remaining_d = C_ZERO;
                end else if (mem_ack) begin
                    acc_d       = w_fold;
                    addr_d      = addr_q + 32'd4;
                    remaining_d = remaining_q - C_ONE;
                    if (remaining_q == C_ONE) begin
                        state_d    = S_DONE;
                        checksum_d = w_fold;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode so that
        // mem_req never depends combinationally on mem_ack.
        mem_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_cksum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_cksum_ctrl
//  Purpose  : Directed self-checking bench for xor_cksum_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_cksum_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        abort;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int vectors;
    int miscompares;

    logic [31:0] mem_w [0:3];

`ifdef XOR_CKSUM_ROTATE_EN
    localparam logic [31:0] EXP_CK3  = 32'h0EF2F10D;
    localparam logic [31:0] EXP_CK2  = 32'h00FEFF01;
`else
    localparam logic [31:0] EXP_CK3  = 32'h0FF0F00F;
    localparam logic [31:0] EXP_CK2  = 32'h00FFFF00;
`endif
    localparam logic [31:0] EXP_CK1  = 32'h0000FFFF;

    xor_cksum_ctrl #(.LEN_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a run at the current negedge and plays the memory side.
    // Returns at the negedge where done is seen (done_cyc = cycle number
    // counted from the start edge), or right after the abort edge.
    task automatic run_block(input logic [31:0] base, input logic [15:0] cnt,
                             input int waits, input int abort_word,
                             output int done_cyc, output int req_cycles,
                             output logic addr_ok, output logic [31:0] a0,
                             output logic [31:0] a1);
        int idx;
        int wcnt;
        logic [31:0] exp_a;
        idx = 0; wcnt = 0; done_cyc = -1; req_cycles = 0; addr_ok = 1'b1;
        a0 = 32'hDEADBEEF; a1 = 32'hDEADBEEF;
        start = 1'b1; base_addr = base; word_count = cnt;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            mem_ack = 1'b0;
            abort   = 1'b0;
            if (mem_req) begin
                req_cycles++;
                exp_a = {base[31:2], 2'b00} + 32'(4 * idx);
                if (mem_addr !== exp_a) addr_ok = 1'b0;
                if (wcnt == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_w[idx];
                    wcnt      = 0;
                    if (idx == 0) a0 = mem_addr;
                    if (idx == 1) a1 = mem_addr;
                    if (abort_word == idx + 1) begin
                        abort = 1'b1;
                        @(negedge clk);
                        mem_ack = 1'b0;
                        abort   = 1'b0;
                        return;
                    end
                    idx++;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_req, busy, done} !== 3'b000 || mem_addr !== 32'h0 || checksum !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: req/busy/done=%b addr=%h ck=%h, required 000 0 0",
                     {mem_req, busy, done}, mem_addr, checksum);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_req, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: req/busy/done=%b, required 000", {mem_req, busy, done});
        end
    endtask

    task automatic test_zero_wait();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        run_block(32'h0000_0100, 16'd3, 0, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (dc !== 4) begin
            miscompares++;
            $display("FAIL zw_done_cycle: got %0d, required 4", dc);
        end
        vectors++;
        if (checksum !== EXP_CK3) begin
            miscompares++;
            $display("FAIL zw_checksum: got %h, required %h", checksum, EXP_CK3);
        end
        vectors++;
        if (!ok || a0 !== 32'h100 || a1 !== 32'h104 || rc !== 3) begin
            miscompares++;
            $display("FAIL zw_addr: ok=%b a0=%h a1=%h reqcyc=%0d, required 1 100 104 3", ok, a0, a1, rc);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL zw_done_pulse: done/busy=%b, required 00", {done, busy});
        end
    endtask

    task automatic test_wait_states();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        run_block(32'h0000_0100, 16'd3, 2, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL ws_done_cycle: got %0d, required 10", dc);
        end
        vectors++;
        if (checksum !== EXP_CK3) begin
            miscompares++;
            $display("FAIL ws_checksum: got %h, required %h", checksum, EXP_CK3);
        end
        vectors++;
        if (!ok || rc !== 9) begin
            miscompares++;
            $display("FAIL ws_addr_stable: ok=%b reqcyc=%0d, required 1 9", ok, rc);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        logic saw_done;
        run_block(32'h0000_0400, 16'd4, 0, 2, dc, rc, ok, a0, a1);
        vectors++;
        if ({mem_req, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_idle: req/busy=%b, required 00", {mem_req, busy});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done || mem_req) saw_done = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: activity=%b, required 0", saw_done);
        end
        vectors++;
        if (checksum !== EXP_CK3) begin
            miscompares++;
            $display("FAIL abort_checksum: got %h, required %h", checksum, EXP_CK3);
        end
    endtask

    task automatic test_empty();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        run_block(32'h0000_0800, 16'd0, 0, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (dc !== 1 || rc !== 0) begin
            miscompares++;
            $display("FAIL empty_timing: done_cyc=%0d reqcyc=%0d, required 1 0", dc, rc);
        end
        vectors++;
        if (checksum !== 32'h0) begin
            miscompares++;
            $display("FAIL empty_checksum: got %h, required 00000000", checksum);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        run_block(32'hFFFF_FFFE, 16'd2, 0, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (a0 !== 32'hFFFF_FFFC || a1 !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap_addr: a0=%h a1=%h, required fffffffc 00000000", a0, a1);
        end
        vectors++;
        if (dc !== 3 || checksum !== EXP_CK2) begin
            miscompares++;
            $display("FAIL wrap_result: done_cyc=%0d ck=%h, required 3 %h", dc, checksum, EXP_CK2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        start = 1'b1; base_addr = 32'h0000_0300; word_count = 16'd4;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({mem_req, busy} !== 2'b11 || checksum !== EXP_CK2) begin
            miscompares++;
            $display("FAIL rst_pre: req/busy=%b ck=%h, required 11 %h", {mem_req, busy}, checksum, EXP_CK2);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, busy, done} !== 3'b000 || checksum !== 32'h0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_async: req/busy/done=%b ck=%h addr=%h, required 000 0 0",
                     {mem_req, busy, done}, checksum, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({mem_req, busy, done} !== 3'b000) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_idle_after: activity=%b, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int dc, rc; logic ok; logic [31:0] a0, a1;
        run_block(32'h0000_0200, 16'd1, 0, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (dc !== 2 || checksum !== EXP_CK1) begin
            miscompares++;
            $display("FAIL b2b_first: done_cyc=%0d ck=%h, required 2 %h", dc, checksum, EXP_CK1);
        end
        // Pulse start during the DONE cycle: must be ignored.
        start = 1'b1; word_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_start_in_done: busy/done=%b, required 00", {busy, done});
        end
        // Start in the first IDLE cycle after done.
        run_block(32'h0000_0200, 16'd2, 0, 0, dc, rc, ok, a0, a1);
        vectors++;
        if (dc !== 3 || checksum !== EXP_CK2) begin
            miscompares++;
            $display("FAIL b2b_second: done_cyc=%0d ck=%h, required 3 %h", dc, checksum, EXP_CK2);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        mem_w[0] = 32'h0000_FFFF;
        mem_w[1] = 32'h00FF_00FF;
        mem_w[2] = 32'h0F0F_0F0F;
        mem_w[3] = 32'h1234_5678;
        reset_n = 1'b0; start = 1'b0; base_addr = 32'h0; word_count = 16'd0;
        abort = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_abort();
        test_empty();
        test_wrap();
        test_reset_mid_run();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
